// File: rtl/sc_axi2regbus_pkg.sv
// Shared definitions for the AXI4-Lite to regbus bridge.
// Holds the AXI response codes, the per-channel FSM state type and the
// helper that turns AxPROT into the regbus access-type field.
package sc_axi2regbus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } sc_a2r_state_t;

  // regbus carries the AXI protection bits in the low bits of a 10-bit type field
  function automatic logic [9:0] prot_to_typ(input logic [2:0] prot);
    return {7'b0, prot};
  endfunction

endpackage

// File: rtl/sc_a2r_waitcnt.sv
// Wait-cycle counter for one regbus channel, with timeout detection.
// Ports: clk/rst; active (channel is in its access state), wat (slave wait
//   this cycle); expired (this wait cycle is the TIMEOUT-th one, abort access).
module sc_a2r_waitcnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic wat,
  output logic expired
);

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);
  localparam logic        TO_EN  = (TIMEOUT != 0);

  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  // saturate so a disabled or huge timeout never wraps back onto TO_VAL
  always_comb begin
    cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  end

  // held at zero outside the access state, so every access starts from 0
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      cnt <= 16'd0;
    end else if (wat) begin
      cnt <= cnt_inc;
    end
  end

  // fires on the wait cycle that brings the count up to TIMEOUT
  always_comb begin
    expired = TO_EN && active && wat && (cnt_inc == TO_VAL);
  end

endmodule

// File: rtl/sc_axi2regbus.sv
// AXI4-Lite slave to Space Cubics regbus master bridge.
// AXI side: AW/W/B and AR/R channels (CLK domain, synchronous active-high RESET).
// Regbus side: WENB/WADR/WDAT/WTYP out, WWAT/WERR in; RENB/RADR/RTYP out, RDAT/RWAT/RERR in.
module sc_axi2regbus
  import sc_axi2regbus_pkg::*;
#(
  parameter int          TIMEOUT   = 256,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  // AXI write address / data / response
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  // AXI read address / data
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  // regbus master
  output logic [3:0]  WENB,
  output logic [31:0] WADR,
  output logic [31:0] WDAT,
  output logic [9:0]  WTYP,
  input  logic        WWAT,
  input  logic        WERR,
  output logic        RENB,
  output logic [31:0] RADR,
  output logic [9:0]  RTYP,
  input  logic [31:0] RDAT,
  input  logic        RWAT,
  input  logic        RERR
);

  sc_a2r_state_t w_state, w_next;
  sc_a2r_state_t r_state, r_next;
  logic [3:0]    w_strb;
  logic          w_take, r_take;
  logic          w_expired, r_expired;

  // AW and W are only taken together; a lone AW or W waits for its partner
  assign w_take = (w_state == IDLE) && AWVALID && WVALID && !RESET;
  assign r_take = (r_state == IDLE) && ARVALID && !RESET;

  sc_a2r_waitcnt #(.TIMEOUT(TIMEOUT)) u_wcnt (
    .clk     (CLK),
    .rst     (RESET),
    .active  (w_state == ACC),
    .wat     (WWAT),
    .expired (w_expired)
  );

  sc_a2r_waitcnt #(.TIMEOUT(TIMEOUT)) u_rcnt (
    .clk     (CLK),
    .rst     (RESET),
    .active  (r_state == ACC),
    .wat     (RWAT),
    .expired (r_expired)
  );

  // ---------------- write channel ----------------
  always_ff @(posedge CLK) begin
    if (RESET) w_state <= IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      // an all-zero strobe has nothing to write: answer OKAY without a bus cycle
      IDLE:    if (AWVALID && WVALID) w_next = (WSTRB == 4'b0) ? RESP : ACC;
      ACC:     if (!WWAT || w_expired) w_next = RESP;
      RESP:    if (BREADY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    WENB    = 4'b0;
    BVALID  = 1'b0;
    case (w_state)
      IDLE: begin
        AWREADY = w_take;
        WREADY  = w_take;
      end
      ACC:     WENB   = w_strb;
      RESP:    BVALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WADR   <= 32'd0;
      WDAT   <= 32'd0;
      WTYP   <= 10'd0;
      w_strb <= 4'b0;
      BRESP  <= RESP_OKAY;
    end else if (w_take) begin
      WADR   <= AWADDR & ADDR_MASK;
      WDAT   <= WDATA;
      WTYP   <= prot_to_typ(AWPROT);
      w_strb <= WSTRB;
      BRESP  <= RESP_OKAY;
    end else if (w_state == ACC) begin
      if (!WWAT)          BRESP <= WERR ? RESP_SLVERR : RESP_OKAY;
      else if (w_expired) BRESP <= RESP_SLVERR;
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      IDLE:    if (ARVALID) r_next = ACC;
      ACC:     if (!RWAT || r_expired) r_next = RESP;
      RESP:    if (RREADY) r_next = IDLE;
      default: r_next = IDLE;
    endcase
  end

  always_comb begin
    ARREADY = 1'b0;
    RENB    = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      IDLE:    ARREADY = r_take;
      ACC:     RENB    = 1'b1;
      RESP:    RVALID  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RADR  <= 32'd0;
      RTYP  <= 10'd0;
      RDATA <= 32'd0;
      RRESP <= RESP_OKAY;
    end else if (r_take) begin
      RADR <= ARADDR & ADDR_MASK;
      RTYP <= prot_to_typ(ARPROT);
    end else if (r_state == ACC) begin
      if (!RWAT) begin
        RDATA <= RDAT;
        RRESP <= RERR ? RESP_SLVERR : RESP_OKAY;
      end else if (r_expired) begin
        RDATA <= 32'd0;
        RRESP <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_sc_axi2regbus.sv
// Bench for sc_axi2regbus: directed cases followed by randomized write/read
// traffic, with expected behaviour computed from the bridge's transaction rules.
module tb_sc_axi2regbus;

  localparam int          TMO  = 8;
  localparam logic [31:0] MASK = 32'h000F_FFFC;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, WADR, WDAT, RADR, RDAT;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB, WENB;
  logic [1:0]  BRESP, RRESP;
  logic [9:0]  WTYP, RTYP;
  logic        WWAT, WERR, RENB, RWAT, RERR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sc_axi2regbus #(.TIMEOUT(TMO), .ADDR_MASK(MASK)) dut (
    .CLK(CLK), .RESET(RESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .WENB(WENB), .WADR(WADR), .WDAT(WDAT), .WTYP(WTYP), .WWAT(WWAT), .WERR(WERR),
    .RENB(RENB), .RADR(RADR), .RTYP(RTYP), .RDAT(RDAT), .RWAT(RWAT), .RERR(RERR)
  );

  // regbus slave: holds wait for a configured number of cycles per access
  int          w_wait_cfg = 0, r_wait_cfg = 0;
  logic        w_err_cfg = 1'b0, r_err_cfg = 1'b0;
  logic [31:0] r_dat_cfg = 32'd0;
  int          w_seen = 0, r_seen = 0;

  always @(posedge CLK) begin
    w_seen <= (WENB != 4'b0) ? w_seen + 1 : 0;
    r_seen <= RENB ? r_seen + 1 : 0;
  end

  assign WWAT = (WENB != 4'b0) && (w_seen < w_wait_cfg);
  assign WERR = w_err_cfg;
  assign RWAT = RENB && (r_seen < r_wait_cfg);
  assign RERR = r_err_cfg;
  assign RDAT = r_dat_cfg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: number of enable cycles an access lasts and its response
  function automatic int exp_enb_cycles(input int nwait, input bit access);
    if (!access) return 0;
    return (nwait >= TMO) ? TMO : nwait + 1;
  endfunction

  function automatic logic [1:0] exp_resp(input int nwait, input bit access, input bit err);
    if (!access) return 2'b00;
    if (nwait >= TMO) return 2'b10;
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int nwait, input bit err, input int bdelay, input bit skew);
    int          n, lat, enb, exp_n;
    logic [1:0]  er;
    logic [3:0]  wenb_v;
    logic [31:0] wadr_v, wdat_v;
    logic [9:0]  wtyp_v;
    exp_n = exp_enb_cycles(nwait, strb != 4'b0);
    er    = exp_resp(nwait, strb != 4'b0, err);
    @(posedge CLK); #1;
    w_wait_cfg = nwait; w_err_cfg = err;
    AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = !skew;
    if (skew) begin
      repeat (2) begin
        @(negedge CLK);
        check("aw_only_rdy", 32'(AWREADY), 32'd0);
      end
      WVALID = 1'b1;
    end
    #1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin @(negedge CLK); n++; end
    check("w_hs", 32'(AWREADY && WREADY), 32'd1);
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    lat = 0; enb = 0; wenb_v = '0; wadr_v = '0; wdat_v = '0; wtyp_v = '0;
    do begin
      @(negedge CLK);
      lat++;
      if (WENB != 4'b0) begin
        enb++; wenb_v = WENB; wadr_v = WADR; wdat_v = WDAT; wtyp_v = WTYP;
      end
    end while (!BVALID && lat < 40);
    check("w_lat", 32'(lat), 32'(1 + exp_n));
    check("w_enb_cycles", 32'(enb), 32'(exp_n));
    if (exp_n > 0) begin
      check("wenb", 32'(wenb_v), 32'(strb));
      check("wadr", wadr_v, addr & MASK);
      check("wdat", wdat_v, data);
      check("wtyp", 32'(wtyp_v), 32'(prot));
    end
    check("bresp", 32'(BRESP), 32'(er));
    // offer another write while the response is pending; it must not be taken
    AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge CLK);
      check("bvalid_hold", 32'(BVALID), 32'd1);
      check("bresp_hold", 32'(BRESP), 32'(er));
      check("aw_blocked", 32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge CLK);
    check("bvalid_clr", 32'(BVALID), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                         input int nwait, input bit err, input logic [31:0] rdat,
                         input int rdelay);
    int          n, lat, enb, exp_n;
    logic [1:0]  er;
    logic [31:0] radr_v, exp_data;
    logic [9:0]  rtyp_v;
    exp_n    = exp_enb_cycles(nwait, 1'b1);
    er       = exp_resp(nwait, 1'b1, err);
    exp_data = (nwait >= TMO) ? 32'd0 : rdat;
    @(posedge CLK); #1;
    r_wait_cfg = nwait; r_err_cfg = err; r_dat_cfg = rdat;
    ARADDR = addr; ARPROT = prot; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge CLK); n++; end
    check("r_hs", 32'(ARREADY), 32'd1);
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    lat = 0; enb = 0; radr_v = '0; rtyp_v = '0;
    do begin
      @(negedge CLK);
      lat++;
      if (RENB) begin enb++; radr_v = RADR; rtyp_v = RTYP; end
    end while (!RVALID && lat < 40);
    check("r_lat", 32'(lat), 32'(1 + exp_n));
    check("r_enb_cycles", 32'(enb), 32'(exp_n));
    check("radr", radr_v, addr & MASK);
    check("rtyp", 32'(rtyp_v), 32'(prot));
    check("rdata", RDATA, exp_data);
    check("rresp", 32'(RRESP), 32'(er));
    ARVALID = 1'b1;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge CLK);
      check("rvalid_hold", 32'(RVALID), 32'd1);
      check("rdata_hold", RDATA, exp_data);
      check("ar_blocked", 32'(ARREADY), 32'd0);
    end
    RREADY = 1'b1;
    @(posedge CLK); #1;
    RREADY = 1'b0; ARVALID = 1'b0;
    @(negedge CLK);
    check("rvalid_clr", 32'(RVALID), 32'd0);
  endtask

  task automatic reset_mid_write();
    int  n;
    bit  bv_seen;
    @(posedge CLK); #1;
    w_wait_cfg = 50; w_err_cfg = 1'b0;
    AWADDR = 32'h100; AWPROT = 3'd0; WDATA = 32'h5555_AAAA; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin @(negedge CLK); n++; end
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_pre_wenb", 32'(WENB), 32'hF);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_wenb", 32'(WENB), 32'd0);
    check("rst_wadr", WADR, 32'd0);
    bv_seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (BVALID || WENB != 4'b0) bv_seen = 1'b1;
    end
    check("rst_no_bvalid", 32'(bv_seen), 32'd0);
    w_wait_cfg = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_rdy", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    check("rst_valid", {30'd0, BVALID, RVALID}, 32'd0);
    check("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_enb", {27'd0, WENB, RENB}, 32'd0);
    check("rst_adr", WADR | RADR | WDAT, 32'd0);
    check("rst_typ", {12'd0, WTYP, RTYP}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 0, 1'b0);
    do_read(32'h20, 3'd2, 3, 1'b0, 32'h12345678, 0);
    do_write(32'h44, 32'h0000_0001, 4'h3, 3'd1, 1, 1'b1, 1, 1'b0);
    do_read(32'h48, 3'd0, 0, 1'b1, 32'h0000_CAFE, 1);
    do_read(32'h4C, 3'd4, 30, 1'b0, 32'hFFFF_0000, 0);
    do_write(32'h50, 32'h1234_5678, 4'h0, 3'd0, 0, 1'b0, 0, 1'b0);
    do_write(32'h54, 32'hA5A5_A5A5, 4'hC, 3'd3, 0, 1'b0, 0, 1'b1);
    fork
      do_write(32'h60, 32'h0BAD_F00D, 4'hF, 3'd5, 2, 1'b0, 5, 1'b0);
      do_read(32'h64, 3'd6, 1, 1'b0, 32'h7777_1111, 5);
    join
    reset_mid_write();

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a, d, rd;
      logic [3:0]  s;
      int          sel;
      a   = $urandom;
      d   = $urandom;
      rd  = $urandom;
      s   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        do_write(a, d, s, 3'($urandom_range(0, 7)), $urandom_range(0, 10),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
      end else if (sel == 1) begin
        do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 10),
                1'($urandom_range(0, 1)), rd, $urandom_range(0, 3));
      end else begin
        fork
          do_write(a, d, s, 3'($urandom_range(0, 7)), $urandom_range(0, 10),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
          do_read(~a, 3'($urandom_range(0, 7)), $urandom_range(0, 10),
                  1'($urandom_range(0, 1)), rd, $urandom_range(0, 3));
        join
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
